spi_slave_word: RTL and testbench

//  Parametrised full-duplex SPI slave: runtime-selectable SPI mode (CPOL/CPHA), configurable word width and bit order.

---
 rtl/spi_slave_word.sv | 177 +++++++++++++++++
 tb/tb_spi_slave_word.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word.sv
//==============================================================================
// spi_slave_word : full-duplex SPI slave, runtime CPOL/CPHA, word framing with
//                  valid/ready rx and reloaded tx. Option: SPI_SLAVE_OVERRUN_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_slave_word #(
  parameter int WORD_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  output logic [WORD_WIDTH-1:0] rxData,
  output logic                  rxValid,
  input  logic                  rxReady,
  input  logic [WORD_WIDTH-1:0] txData,
  output logic                  txLoad,
  output logic                  overrun,
  output logic                  busy,
  output logic                  miso,
  output logic                  misoEn,
  input  logic                  rawSCLK,
  input  logic                  rawMOSI,
  input  logic                  rawCS
);

  localparam int              CNT_W    = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);
  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       ACTIVE   = 1'b1;

  logic [SYNC_STAGES:0]   sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   cs_prev;

  logic [0:0]            state, state_next;
  logic [1:0]            mode_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [WORD_WIDTH-1:0] rx_shift, rx_next;
  logic [WORD_WIDTH-1:0] tx_shift, tx_next;
  logic                  tx_bit;
  logic                  word_done, word_accept;

  logic sclk_s, sclk_d, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, word_last;
  logic start, active_run, do_sample, tx_reload, tx_shift_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], rawSCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], rawMOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], rawCS};
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign sclk_d      = sclk_sync[SYNC_STAGES];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev & ~cs_s;
  assign word_last   = (bit_cnt == LAST_BIT);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign rx_next = {rx_shift[WORD_WIDTH-2:0], mosi_s};
      assign tx_next = {tx_shift[WORD_WIDTH-2:0], 1'b0};
      assign tx_bit  = tx_shift[WORD_WIDTH-1];
    end else begin : g_lsb_first
      assign rx_next = {mosi_s, rx_shift[WORD_WIDTH-1:1]};
      assign tx_next = {1'b0, tx_shift[WORD_WIDTH-1:1]};
      assign tx_bit  = tx_shift[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_s)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A CS release cycle is not allowed to sample or shift: the frame is already over.
  always_comb begin
    start       = (state == IDLE) & cs_fall;
    active_run  = (state == ACTIVE) & ~cs_s;
    do_sample   = active_run & sample_edge;
    tx_reload   = mode_q[0] ? (do_sample & word_last)
                            : (active_run & trail_edge & (bit_cnt == '0));
    tx_shift_en = active_run & shift_edge & ~tx_reload & (~mode_q[0] | (bit_cnt != '0));
    txLoad      = start | tx_reload;
    busy        = (state == ACTIVE);
    misoEn      = (state == ACTIVE);
    miso        = (state == ACTIVE) & tx_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= 2'b00;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= do_sample & word_last;
      if (start) begin
        mode_q  <= mode;
        bit_cnt <= '0;
      end else if ((state == ACTIVE) && cs_s) begin
        bit_cnt <= '0;
      end else if (do_sample) begin
        bit_cnt <= word_last ? '0 : bit_cnt + 1'b1;
      end
      if (do_sample) rx_shift <= rx_next;
      if (txLoad)           tx_shift <= txData;
      else if (tx_shift_en) tx_shift <= tx_next;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q;
  logic word_drop;

  assign word_drop   = word_done & rxValid & ~rxReady;
  assign word_accept = word_done & ~word_drop;
  assign overrun     = overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         overrun_q <= 1'b0;
    else if (word_drop) overrun_q <= 1'b1;
    else if (start)     overrun_q <= 1'b0;
  end
`else
  assign word_accept = word_done;
  assign overrun     = 1'b0;
`endif

  // A word landing in the handshake cycle re-arms rxValid: new data wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxData  <= '0;
      rxValid <= 1'b0;
    end else if (word_accept) begin
      rxData  <= rx_shift;
      rxValid <= 1'b1;
    end else if (rxValid && rxReady) begin
      rxValid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_word.sv
//==============================================================================
// tb_spi_slave_word : directed bench acting as SPI master around spi_slave_word.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_slave_word;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int HALF = 60;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] rxData;
  logic         rxValid;
  logic         rxReady = 1'b0;
  logic [W-1:0] txData = '0;
  logic         txLoad, overrun, busy, miso, misoEn;
  logic         rawSCLK = 1'b0, rawMOSI = 1'b0, rawCS = 1'b1;

  always #5 clk = ~clk;

  spi_slave_word #(.WORD_WIDTH(W), .SYNC_STAGES(S), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
    .txData(txData), .txLoad(txLoad), .overrun(overrun),
    .busy(busy), .miso(miso), .misoEn(misoEn),
    .rawSCLK(rawSCLK), .rawMOSI(rawMOSI), .rawCS(rawCS)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] got_q[$];
  int           load_cnt = 0;
  time          last_smp_t = 0;
  time          rxv_t = 0;
  logic [W-1:0] mo_w[4];
  logic [W-1:0] so_w[4];
  logic [W-1:0] mi_w[4];
  bit           cpol, cpha;

  always @(negedge clk) begin
    if (rxValid && rxReady) got_q.push_back(rxData);
    if (txLoad) load_cnt++;
  end

  always @(posedge rxValid) rxv_t = $time;

  function automatic logic [W-1:0] q_at(input int idx);
    if (got_q.size() > idx) return got_q[idx];
    return '0;
  endfunction

  task automatic send_bits(input int word, input int nbits);
    int b;
    for (int i = 0; i < nbits; i++) begin
      b = W - 1 - i;
      if (i == 4 && word < 3) txData = so_w[word+1];
      if (!cpha) begin
        rawMOSI = mo_w[word][b];
        #HALF;
        rawSCLK = ~cpol;
        mi_w[word][b] = miso;
        last_smp_t = $time;
        #HALF;
        rawSCLK = cpol;
      end else begin
        rawSCLK = ~cpol;
        rawMOSI = mo_w[word][b];
        #HALF;
        rawSCLK = cpol;
        mi_w[word][b] = miso;
        last_smp_t = $time;
        #HALF;
      end
    end
  endtask

  task automatic cs_start(input logic [1:0] m);
    cpol    = m[1];
    cpha    = m[0];
    mode    = m;
    rawSCLK = m[1];
    txData  = so_w[0];
    repeat (8) @(negedge clk);
    rawCS = 1'b0;
    repeat (8) @(negedge clk);
    mode = ~m;
  endtask

  task automatic cs_end();
    #HALF;
    rawCS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rxReady = v;
  endtask

  int base_q, base_l;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rxdata",  32'(rxData),  32'h0);
    check("rst_rxvalid", 32'(rxValid), 32'h0);
    check("rst_txload",  32'(txLoad),  32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_miso",    32'(miso),    32'h0);
    check("rst_misoen",  32'(misoEn),  32'h0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // mode 0, consumer not ready: data held until handshake
    mo_w[0] = 8'hA5; so_w[0] = 8'h3C; so_w[1] = 8'h00;
    base_l = load_cnt;
    cs_start(2'd0);
    check("m0_busy", 32'(busy & misoEn), 32'h1);
    send_bits(0, 8);
    cs_end();
    check("m0_rxdata",  32'(rxData),  32'hA5);
    check("m0_rxvalid", 32'(rxValid), 32'h1);
    check("m0_master",  32'(mi_w[0]), 32'h3C);
    check("m0_latency", 32'(rxv_t - last_smp_t), 32'((S + 2) * 10 - 5));
    check("m0_txload",  32'(load_cnt - base_l), 32'd2);
    check("m0_idle",    32'(busy | misoEn | miso), 32'h0);
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    check("m0_handshake", 32'(rxValid), 32'h0);
    set_ready(1'b1);

    for (int m = 1; m < 4; m++) begin
      mo_w[0] = 8'h5A; so_w[0] = 8'hC3;
      base_q = got_q.size();
      base_l = load_cnt;
      cs_start(2'(m));
      send_bits(0, 8);
      cs_end();
      check($sformatf("mode%0d_count", m),  32'(got_q.size() - base_q), 32'd1);
      check($sformatf("mode%0d_rx", m),     32'(q_at(base_q)), 32'h5A);
      check($sformatf("mode%0d_master", m), 32'(mi_w[0]), 32'hC3);
      check($sformatf("mode%0d_txload", m), 32'(load_cnt - base_l), 32'd2);
    end

    // two-word frame, mode 0
    mo_w[0] = 8'h12; mo_w[1] = 8'h34; so_w[0] = 8'h96; so_w[1] = 8'h69; so_w[2] = 8'h00;
    base_q = got_q.size();
    base_l = load_cnt;
    cs_start(2'd0);
    send_bits(0, 8);
    send_bits(1, 8);
    cs_end();
    check("two_count",   32'(got_q.size() - base_q), 32'd2);
    check("two_rx0",     32'(q_at(base_q)), 32'h12);
    check("two_rx1",     32'(q_at(base_q + 1)), 32'h34);
    check("two_master0", 32'(mi_w[0]), 32'h96);
    check("two_master1", 32'(mi_w[1]), 32'h69);
    check("two_txload",  32'(load_cnt - base_l), 32'd3);

    // CS released after 5 bits
    mo_w[0] = 8'hFF; so_w[0] = 8'hFF; so_w[1] = 8'hFF;
    base_q = got_q.size();
    cs_start(2'd0);
    send_bits(0, 5);
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'h1);
    rawCS = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1;
    check("abort_busy",  32'(busy | misoEn), 32'h0);
    check("abort_miso",  32'(miso), 32'h0);
    repeat (8) @(negedge clk);
    check("abort_norx", 32'(got_q.size() - base_q), 32'd0);
    mo_w[0] = 8'h81; so_w[0] = 8'h55; so_w[1] = 8'h00;
    cs_start(2'd0);
    send_bits(0, 8);
    cs_end();
    check("abort_next_rx",     32'(q_at(base_q)), 32'h81);
    check("abort_next_master", 32'(mi_w[0]), 32'h55);

    // consumer stalled across two words
    set_ready(1'b0);
    mo_w[0] = 8'h11; mo_w[1] = 8'h22; so_w[0] = 8'h00; so_w[1] = 8'h00;
    cs_start(2'd0);
    send_bits(0, 8);
    send_bits(1, 8);
    cs_end();
`ifdef SPI_SLAVE_OVERRUN_EN
    check("ovr_rxdata",  32'(rxData),  32'h11);
    check("ovr_flag",    32'(overrun), 32'h1);
`else
    check("ovr_rxdata",  32'(rxData),  32'h22);
    check("ovr_flag",    32'(overrun), 32'h0);
`endif
    check("ovr_rxvalid", 32'(rxValid), 32'h1);
    set_ready(1'b1);
    repeat (2) @(negedge clk);
    mo_w[0] = 8'h77;
    base_q = got_q.size();
    cs_start(2'd1);
    check("ovr_clear", 32'(overrun), 32'h0);
    send_bits(0, 8);
    cs_end();
    check("ovr_after_rx", 32'(q_at(base_q)), 32'h77);

    // reset mid-word
    mo_w[0] = 8'hC0;
    cs_start(2'd3);
    send_bits(0, 4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_busy",    32'(busy | misoEn), 32'h0);
    check("mrst_miso",    32'(miso),    32'h0);
    check("mrst_rxvalid", 32'(rxValid), 32'h0);
    check("mrst_rxdata",  32'(rxData),  32'h0);
    check("mrst_overrun", 32'(overrun), 32'h0);
    check("mrst_txload",  32'(txLoad),  32'h0);
    rawCS = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    mo_w[0] = 8'hF0; so_w[0] = 8'h0F;
    base_q = got_q.size();
    cs_start(2'd3);
    send_bits(0, 8);
    cs_end();
    check("mrst_next_rx",     32'(q_at(base_q)), 32'hF0);
    check("mrst_next_master", 32'(mi_w[0]), 32'h0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
